// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// ----------------
// Shares the single-port instruction ROM between the fetch stage (port F)
// and the memory stage (port D, loads from the text/constant region).
// The ROM has a fixed pipelined read latency (LATENCY). A shift register
// records which requester owns each in-flight read so that the returning
// data is steered to the right valid strobe. Data reads normally win a
// conflict. After STARVE_MAX consecutive lost conflicts, fetch gets one
// priority win.
//
// Optional feature: define ROM_ARB_PERF_EN to add three 32-bit wrapping
// performance counters (perf_f_grants, perf_d_grants, perf_conflicts).
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   f_req/f_addr        fetch read request and byte address
//   f_flush             discard in-flight fetch reads (redirect)
//   f_gnt/f_stall       fetch accepted / fetch must hold its PC
//   f_rvalid/f_rdata    fetch read response
//   d_req/d_addr        data read request and byte address
//   d_gnt               data accepted
//   d_rvalid/d_rdata    data read response
//   mem_en/mem_addr     ROM read enable and word-aligned address
//   mem_dout            ROM read data, LATENCY cycles after mem_en
//   perf_*              (ROM_ARB_PERF_EN only) event counters
module rom_port_arbiter #(
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic        f_flush,
    output logic        f_gnt,
    output logic        f_stall,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_dout
`ifdef ROM_ARB_PERF_EN
    ,
    output logic [31:0] perf_f_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_conflicts
`endif
);

    localparam logic [0:0] DATA_PRI   = 1'b0;
    localparam logic [0:0] FETCH_PRI  = 1'b1;
    localparam logic [4:0] STARVE_LIM = 5'(STARVE_MAX);

    logic [0:0]         state_q, state_d;
    logic [3:0]         starve_q, starve_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] id_q, id_d;   // 0 = fetch, 1 = data
    logic               lost;
    logic [31:0]        gnt_addr;

    // Grants are purely combinational so a request is accepted in its own cycle.
    assign f_gnt   = f_req & (~d_req | (state_q == FETCH_PRI));
    assign d_gnt   = d_req & (~f_req | (state_q == DATA_PRI));
    assign f_stall = f_req & ~f_gnt;
    assign mem_en  = f_gnt | d_gnt;
    assign lost    = f_req & d_req & d_gnt;

    // The byte offset is simply dropped; misaligned addresses are not flagged.
    assign gnt_addr = f_gnt ? f_addr : d_addr;
    assign mem_addr = mem_en ? (gnt_addr & 32'hFFFF_FFFC) : 32'h0000_0000;

    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        if (f_gnt || !f_req) begin
            starve_d = 4'd0;
        end else if (lost && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end
        // Widen by one bit so the saturated count cannot wrap in the compare.
        if ((state_q == DATA_PRI) && lost && (({1'b0, starve_q} + 5'd1) >= STARVE_LIM)) begin
            state_d = FETCH_PRI;
        end else if ((state_q == FETCH_PRI) && f_gnt) begin
            state_d = DATA_PRI;
        end
    end

    // Flush kills every fetch-owned entry, including the one loading this cycle.
    always_comb begin
        vld_d    = '0;
        id_d     = '0;
        vld_d[0] = mem_en & ~(f_flush & ~d_gnt);
        id_d[0]  = d_gnt;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1] & ~(f_flush & ~id_q[i-1]);
            id_d[i]  = id_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= DATA_PRI;
            starve_q <= 4'd0;
            vld_q    <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            vld_q    <= vld_d;
            id_q     <= id_d;
        end
    end

    assign f_rvalid = vld_q[LATENCY-1] & ~id_q[LATENCY-1];
    assign d_rvalid = vld_q[LATENCY-1] &  id_q[LATENCY-1];
    assign f_rdata  = mem_dout;
    assign d_rdata  = mem_dout;

`ifdef ROM_ARB_PERF_EN
    logic [31:0] perf_f_q, perf_d_q, perf_c_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_f_q <= 32'd0;
            perf_d_q <= 32'd0;
            perf_c_q <= 32'd0;
        end else begin
            perf_f_q <= perf_f_q + {31'd0, f_gnt};
            perf_d_q <= perf_d_q + {31'd0, d_gnt};
            perf_c_q <= perf_c_q + {31'd0, f_req & d_req};
        end
    end

    assign perf_f_grants  = perf_f_q;
    assign perf_d_grants  = perf_d_q;
    assign perf_conflicts = perf_c_q;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed testbench for rom_port_arbiter. Three instances (LATENCY 1, 2, 3,
// STARVE_MAX 3) share the same request stimulus; each has its own ROM model
// returning (word address ^ K) after its latency.
module tb_rom_port_arbiter;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic f_req = 1'b0, d_req = 1'b0, f_flush = 1'b0;
    logic [31:0] f_addr = 32'h0, d_addr = 32'h0;

    logic fg1, fs1, frv1, dg1, drv1, me1;
    logic fg2, fs2, frv2, dg2, drv2, me2;
    logic fg3, fs3, frv3, dg3, drv3, me3;
    logic [31:0] frd1, drd1, ma1, md1;
    logic [31:0] frd2, drd2, ma2, md2;
    logic [31:0] frd3, drd3, ma3, md3;
    logic [31:0] p1, p2a, p2b, p3a, p3b, p3c;
`ifdef ROM_ARB_PERF_EN
    logic [31:0] pf1, pd1, pc1, pf2, pd2, pc2, pf3, pd3, pc3;
`endif

    int vecs = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(.LATENCY(1), .STARVE_MAX(3)) u1 (
        .clk(clk), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
        .f_gnt(fg1), .f_stall(fs1), .f_rvalid(frv1), .f_rdata(frd1),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(dg1), .d_rvalid(drv1), .d_rdata(drd1),
        .mem_en(me1), .mem_addr(ma1), .mem_dout(md1)
`ifdef ROM_ARB_PERF_EN
        , .perf_f_grants(pf1), .perf_d_grants(pd1), .perf_conflicts(pc1)
`endif
    );

    rom_port_arbiter #(.LATENCY(2), .STARVE_MAX(3)) u2 (
        .clk(clk), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
        .f_gnt(fg2), .f_stall(fs2), .f_rvalid(frv2), .f_rdata(frd2),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(dg2), .d_rvalid(drv2), .d_rdata(drd2),
        .mem_en(me2), .mem_addr(ma2), .mem_dout(md2)
`ifdef ROM_ARB_PERF_EN
        , .perf_f_grants(pf2), .perf_d_grants(pd2), .perf_conflicts(pc2)
`endif
    );

    rom_port_arbiter #(.LATENCY(3), .STARVE_MAX(3)) u3 (
        .clk(clk), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
        .f_gnt(fg3), .f_stall(fs3), .f_rvalid(frv3), .f_rdata(frd3),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(dg3), .d_rvalid(drv3), .d_rdata(drd3),
        .mem_en(me3), .mem_addr(ma3), .mem_dout(md3)
`ifdef ROM_ARB_PERF_EN
        , .perf_f_grants(pf3), .perf_d_grants(pd3), .perf_conflicts(pc3)
`endif
    );

    // ROM models: fixed pipelined latency per instance.
    always @(posedge clk) begin
        p1  <= ma1 ^ K;
        p2a <= ma2 ^ K;
        p2b <= p2a;
        p3a <= ma3 ^ K;
        p3b <= p3a;
        p3c <= p3b;
    end
    assign md1 = p1;
    assign md2 = p2b;
    assign md3 = p3c;

    // One cycle: change inputs at the falling edge, then settle before checks.
    task automatic cyc(input logic fr, input logic [31:0] fa, input logic dr,
                       input logic [31:0] da, input logic fl);
        @(negedge clk);
        f_req = fr; f_addr = fa; d_req = dr; d_addr = da; f_flush = fl;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vecs++; if ({frv1, drv1, frv2, drv2, frv3, drv3} !== 6'b0) begin fails++; $display("FAIL reset_rvalid: got %b want 000000", {frv1, drv1, frv2, drv2, frv3, drv3}); end
        vecs++; if ({me1, fg1, dg1, fs1} !== 4'b0) begin fails++; $display("FAIL reset_ctrl: got %b want 0000", {me1, fg1, dg1, fs1}); end
        vecs++; if (ma1 !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h want 00000000", ma1); end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        idle(2);
        vecs++; if ({frv1, drv1, frv2, drv2, frv3, drv3} !== 6'b0) begin fails++; $display("FAIL post_reset_rvalid: got %b want 000000", {frv1, drv1, frv2, drv2, frv3, drv3}); end
    endtask

    task automatic test_single_fetch;
        logic [31:0] a [3];
        a[0] = 32'h0040_0000; a[1] = 32'h0040_0004; a[2] = 32'h0040_0008;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, a[i], 1'b0, 32'h0, 1'b0);
            vecs++; if ({fg1, fs1, dg1, me1} !== 4'b1001) begin fails++; $display("FAIL fetch_gnt[%0d]: got %b want 1001", i, {fg1, fs1, dg1, me1}); end
            vecs++; if (ma1 !== a[i]) begin fails++; $display("FAIL fetch_mem_addr[%0d]: got %h want %h", i, ma1, a[i]); end
            if (i == 0) begin
                vecs++; if (frv1 !== 1'b0) begin fails++; $display("FAIL fetch_rvalid_first: got %b want 0", frv1); end
            end else begin
                vecs++; if ({frv1, drv1} !== 2'b10 || frd1 !== (a[i-1] ^ K)) begin fails++; $display("FAIL fetch_resp[%0d]: got v=%b%b d=%h want v=10 d=%h", i, frv1, drv1, frd1, a[i-1] ^ K); end
            end
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vecs++; if ({frv1, drv1} !== 2'b10 || frd1 !== (a[2] ^ K)) begin fails++; $display("FAIL fetch_resp_last: got v=%b%b d=%h want v=10 d=%h", frv1, drv1, frd1, a[2] ^ K); end
        vecs++; if (me1 !== 1'b0 || ma1 !== 32'h0) begin fails++; $display("FAIL idle_mem: got en=%b addr=%h want en=0 addr=0", me1, ma1); end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vecs++; if (frv1 !== 1'b0) begin fails++; $display("FAIL fetch_rvalid_drain: got %b want 0", frv1); end
        idle(3);
    endtask

    task automatic test_conflict;
        cyc(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0102, 1'b0);
        vecs++; if ({fg1, dg1, fs1, me1} !== 4'b0111) begin fails++; $display("FAIL conflict_gnt: got %b want 0111", {fg1, dg1, fs1, me1}); end
        vecs++; if (ma1 !== 32'h0040_0100) begin fails++; $display("FAIL conflict_mem_addr: got %h want 00400100", ma1); end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vecs++; if ({frv1, drv1} !== 2'b01 || drd1 !== (32'h0040_0100 ^ K)) begin fails++; $display("FAIL conflict_resp: got v=%b%b d=%h want v=01 d=%h", frv1, drv1, drd1, 32'h0040_0100 ^ K); end
        idle(3);
    endtask

    task automatic test_starvation;
        logic [4:0] exp_f;
        exp_f = 5'b01000;  // cycle index 3 (4th cycle) is the fetch win
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0030, 1'b0);
            vecs++; if ({fg1, dg1, fs1} !== {exp_f[i], ~exp_f[i], ~exp_f[i]}) begin fails++; $display("FAIL starve_cycle%0d: got f/d/stall=%b want %b", i + 1, {fg1, dg1, fs1}, {exp_f[i], ~exp_f[i], ~exp_f[i]}); end
        end
        idle(4);
    endtask

    task automatic test_back_to_back;
        cyc(1'b1, 32'h0040_0300, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h0040_0307, 1'b0);
        vecs++; if (ma2 !== 32'h0040_0304) begin fails++; $display("FAIL b2b_mem_addr: got %h want 00400304", ma2); end
        cyc(1'b1, 32'h0040_0308, 1'b0, 32'h0, 1'b0);
        vecs++; if ({frv2, drv2} !== 2'b10 || frd2 !== (32'h0040_0300 ^ K)) begin fails++; $display("FAIL b2b_resp0: got v=%b%b d=%h want v=10 d=%h", frv2, drv2, frd2, 32'h0040_0300 ^ K); end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vecs++; if ({frv2, drv2} !== 2'b01 || drd2 !== (32'h0040_0304 ^ K)) begin fails++; $display("FAIL b2b_resp1: got v=%b%b d=%h want v=01 d=%h", frv2, drv2, drd2, 32'h0040_0304 ^ K); end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vecs++; if ({frv2, drv2} !== 2'b10 || frd2 !== (32'h0040_0308 ^ K)) begin fails++; $display("FAIL b2b_resp2: got v=%b%b d=%h want v=10 d=%h", frv2, drv2, frd2, 32'h0040_0308 ^ K); end
        idle(4);
    endtask

    task automatic test_flush;
        cyc(1'b1, 32'h0040_0200, 1'b0, 32'h0, 1'b0);           // t
        cyc(1'b1, 32'h0040_0204, 1'b0, 32'h0, 1'b1);           // t+1, flush
        vecs++; if (fg2 !== 1'b1) begin fails++; $display("FAIL flush_gnt: got %b want 1", fg2); end
        cyc(1'b0, 32'h0, 1'b1, 32'h0040_0208, 1'b0);           // t+2
        vecs++; if ({frv2, drv2, dg2} !== 3'b001) begin fails++; $display("FAIL flush_t2: got rv/dg=%b want 001", {frv2, drv2, dg2}); end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);                   // t+3, flush over a data read
        vecs++; if ({frv2, drv2} !== 2'b00) begin fails++; $display("FAIL flush_t3: got %b want 00", {frv2, drv2}); end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);                   // t+4
        vecs++; if ({frv2, drv2} !== 2'b01 || drd2 !== (32'h0040_0208 ^ K)) begin fails++; $display("FAIL flush_t4: got v=%b%b d=%h want v=01 d=%h", frv2, drv2, drd2, 32'h0040_0208 ^ K); end
        idle(4);
    endtask

    task automatic test_reset_midflight;
        cyc(1'b1, 32'h0040_0400, 1'b0, 32'h0, 1'b0);           // c0 fetch
        cyc(1'b0, 32'h0, 1'b1, 32'h0040_0500, 1'b0);           // c1 data
        cyc(1'b1, 32'h0040_0404, 1'b1, 32'h0040_0504, 1'b0);   // c2 conflict
        cyc(1'b1, 32'h0040_0404, 1'b1, 32'h0040_0508, 1'b0);   // c3 conflict
        vecs++; if ({frv3, drv3} !== 2'b10 || frd3 !== (32'h0040_0400 ^ K)) begin fails++; $display("FAIL lat3_f_resp: got v=%b%b d=%h want v=10 d=%h", frv3, drv3, frd3, 32'h0040_0400 ^ K); end
        cyc(1'b1, 32'h0040_0404, 1'b1, 32'h0040_050C, 1'b0);   // c4 conflict -> fetch priority
        vecs++; if ({frv3, drv3} !== 2'b01 || drd3 !== (32'h0040_0500 ^ K)) begin fails++; $display("FAIL lat3_d_resp: got v=%b%b d=%h want v=01 d=%h", frv3, drv3, drd3, 32'h0040_0500 ^ K); end
        cyc(1'b1, 32'h0040_0404, 1'b1, 32'h0040_0510, 1'b0);   // c5
        vecs++; if ({fg3, dg3, drv3} !== 3'b101) begin fails++; $display("FAIL pre_reset: got fg/dg/drv=%b want 101", {fg3, dg3, drv3}); end
        reset = 1'b1;
        #1;
        vecs++; if ({frv3, drv3} !== 2'b00) begin fails++; $display("FAIL async_reset_rvalid: got %b want 00", {frv3, drv3}); end
        vecs++; if ({fg3, dg3} !== 2'b01) begin fails++; $display("FAIL reset_state_data_pri: got fg/dg=%b want 01", {fg3, dg3}); end
        #1;
        reset = 1'b0;
        f_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            vecs++; if ({frv3, drv3} !== 2'b00) begin fails++; $display("FAIL post_reset_drop[%0d]: got %b want 00", i, {frv3, drv3}); end
        end
        idle(2);
    endtask

`ifdef ROM_ARB_PERF_EN
    task automatic test_perf;
        @(negedge clk);
        reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h0040_0600, 1'b1, 32'h0040_0700, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vecs++; if (pc1 !== 32'd10) begin fails++; $display("FAIL perf_conflicts: got %0d want 10", pc1); end
        vecs++; if (pf1 !== 32'd2) begin fails++; $display("FAIL perf_f_grants: got %0d want 2", pf1); end
        vecs++; if (pd1 !== 32'd8) begin fails++; $display("FAIL perf_d_grants: got %0d want 8", pd1); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_fetch();
        test_conflict();
        test_starvation();
        test_back_to_back();
        test_flush();
        test_reset_midflight();
`ifdef ROM_ARB_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-port instruction ROM between two requesters: the fetch stage (port F) and the memory stage (port D, loads from the text/constant region).
- Sits between those stages and the memory_interface ROM controller.
- ROM has a fixed, pipelined read latency; this block tracks which requester owns each in-flight read.
- Produces the fetch stall, so the fetch stage's PC holds while the ROM is busy with data reads.

Parameters:
- LATENCY, 1, ROM read latency in cycles from mem_en to valid mem_dout; legal range 1..4.
- STARVE_MAX, 3, consecutive lost-conflict cycles after which fetch gets priority; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address.
- f_flush  in  1  branch/exception redirect; discards in-flight fetch reads.
- f_gnt  out  1  fetch request accepted this cycle.
- f_stall  out  1  f_req & ~f_gnt; drives the fetch stage stall.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  32  fetch read data.
- d_req  in  1  data read request.
- d_addr  in  32  data byte address.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read data valid.
- d_rdata  out  32  data read data.
- mem_en  out  1  ROM read enable.
- mem_addr  out  32  ROM word address.
- mem_dout  in  32  ROM read data, valid LATENCY cycles after mem_en.

Behaviour:
- **Address path**
  - mem_addr = {granted addr[31:2], 2'b00}. Byte offset is dropped with no alignment check.
  - mem_addr = 0 when mem_en = 0.
- **Grant rules** (combinational from req and the priority state; at most one grant per cycle)
  - Only one requester active: that requester is granted.
  - Both active: the priority-state owner is granted.
  - mem_en = f_gnt | d_gnt.
- **Priority FSM** (two states, DATA_PRI and FETCH_PRI; reset state DATA_PRI)
  - starve_cnt is 4 bits, reset value 0.
  - Conflict lost: f_req & d_req & d_gnt. starve_cnt increments by 1 and saturates at 15.
  - starve_cnt clears to 0 when f_gnt = 1 or f_req = 0.
  - DATA_PRI -> FETCH_PRI on the clock edge where a lost conflict makes starve_cnt+1 >= STARVE_MAX.
  - FETCH_PRI -> DATA_PRI on any clock edge with f_gnt = 1.
  - Otherwise the state holds.
- **In-flight tracking**
  - Shift register of LATENCY entries, each {valid, id}; id 0 = fetch, 1 = data.
  - Entry 0 loads {mem_en, d_gnt} each cycle. All entries advance every cycle; there is no backpressure.
  - Output entry = entry LATENCY-1:
    - f_rvalid = valid & ~id.
    - d_rvalid = valid & id.
    - f_rdata = d_rdata = mem_dout, unqualified.
- **Flush**
  - f_flush = 1 clears valid on every entry with id = 0.
  - This includes the entry being loaded in the same cycle: a fetch granted during flush never returns data.
  - Data entries are unaffected.
  - f_flush does not itself block grants.
- **Reset values**
  - All entries invalid, state DATA_PRI, starve_cnt 0.
  - Registered outputs are 0. f_rvalid and d_rvalid are 0 while reset is asserted.
- **Reset mid-operation:** in-flight reads are dropped; no rvalid appears after reset deasserts for a pre-reset request.
- **Pipelining:** back-to-back grants on consecutive cycles are legal. Throughput is 1 read/cycle; responses return in grant order.

Optional Feature:
- Macro ROM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_f_grants, perf_d_grants and perf_conflicts, each 32 bits.
  - Each counts, respectively, f_gnt cycles, d_gnt cycles and f_req&d_req cycles.
  - Counters wrap at 2^32 and reset to 0.
- Not defined: the ports and counters do not exist; functional behaviour is identical.

Test Plan:
- **Single fetch stream:** LATENCY=1, f_req=1 with f_addr 0x0040_0000, 0x0040_0004, 0x0040_0008 on consecutive cycles, d_req=0 -> f_gnt=1 every cycle, mem_addr follows the same sequence, f_rvalid one cycle later with mem_dout, f_stall=0.
- **Conflict, data priority:** both requesting, d_addr=0x0040_0102 -> d_gnt=1, mem_addr=0x0040_0100, f_stall=1, response returns on d_rvalid only.
- **Starvation:** STARVE_MAX=3, f_req and d_req held high -> d_gnt for 3 cycles, f_gnt on cycle 4, then DATA_PRI and d_gnt on cycle 5.
- **Flush:** LATENCY=2, fetch granted at cycles t and t+1, d granted at t+2, f_flush=1 at t+1 -> no f_rvalid at t+2 or t+3, d_rvalid=1 at t+4.
- **Reset mid-flight:** LATENCY=3, two reads outstanding, reset pulsed asynchronously between edges -> f_rvalid/d_rvalid drop to 0 immediately and stay 0 for 3 cycles after release; state DATA_PRI.
- **Perf counters** (ROM_ARB_PERF_EN): 10 cycles of both requesting from reset with STARVE_MAX=3 -> perf_conflicts=10, perf_f_grants=2, perf_d_grants=8.
